uart_master_tx: RTL and testbench

//  Synthesizable UART transmitter, the driving end of the link that the slave agent receives and monitors.

---
 rtl/uart_master_tx.sv | 181 ++++++++++++++++++
 tb/tb_uart_master_tx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_master_tx.sv
// uart_master_tx: double-buffered UART transmitter (start bit, LSB-first data, optional parity, stop bits).
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_master_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_DIV   = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);
    localparam int BW = (BAUD_DIV >= 2) ? $clog2(BAUD_DIV) : 1;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_WIDTH - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    if (DATA_WIDTH < 5 || DATA_WIDTH > 8) begin : g_bad_width
        $fatal(1, "uart_master_tx: DATA_WIDTH must be 5..8");
    end
    if (BAUD_DIV < 2) begin : g_bad_baud
        $fatal(1, "uart_master_tx: BAUD_DIV must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $fatal(1, "uart_master_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
        $fatal(1, "uart_master_tx: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                state_reg, state_next;
    logic [BW-1:0]         baud_cnt_reg, baud_cnt_next;
    logic [CW-1:0]         bit_cnt_reg, bit_cnt_next;
    logic                  stop_cnt_reg, stop_cnt_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [DATA_WIDTH-1:0] hold_data_reg, hold_data_next;
    logic                  hold_full_reg, hold_full_next;
    logic                  tx_reg, tx_next;
`ifdef UART_TX_PARITY_EN
    logic                  parity_reg, parity_next;
`endif

    logic baud_last, bit_last, stop_last, frame_end, xfer, load;

    assign baud_last = (baud_cnt_reg == BAUD_LAST);
    assign bit_last  = (bit_cnt_reg == BIT_LAST);
    assign stop_last = (stop_cnt_reg == STOP_LAST);
    assign frame_end = (state_reg == STOP) && baud_last && stop_last;
    // The held word goes out either from idle or right at the end of the previous frame.
    assign xfer      = hold_full_reg && ((state_reg == IDLE) || frame_end);
    assign load      = tx_valid && !hold_full_reg;

    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            state_reg     <= IDLE;
            baud_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            stop_cnt_reg  <= 1'b0;
            shift_reg     <= '0;
            hold_data_reg <= '0;
            hold_full_reg <= 1'b0;
            tx_reg        <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg    <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            baud_cnt_reg  <= baud_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            stop_cnt_reg  <= stop_cnt_next;
            shift_reg     <= shift_next;
            hold_data_reg <= hold_data_next;
            hold_full_reg <= hold_full_next;
            tx_reg        <= tx_next;
`ifdef UART_TX_PARITY_EN
            parity_reg    <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        baud_cnt_next  = (state_reg == IDLE || baud_last) ? '0 : baud_cnt_reg + BW'(1);
        bit_cnt_next   = bit_cnt_reg;
        stop_cnt_next  = stop_cnt_reg;
        shift_next     = shift_reg;
        hold_data_next = hold_data_reg;
        hold_full_next = hold_full_reg;
        tx_next        = tx_reg;
`ifdef UART_TX_PARITY_EN
        parity_next    = parity_reg;
`endif

        case (state_reg)
            START: begin
                if (baud_last) begin
                    state_next   = DATA;
                    tx_next      = shift_reg[0];
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (baud_last) begin
                    if (bit_last) begin
`ifdef UART_TX_PARITY_EN
                        state_next    = PARITY;
                        tx_next       = parity_reg;
`else
                        state_next    = STOP;
                        tx_next       = 1'b1;
                        stop_cnt_next = 1'b0;
`endif
                    end else begin
                        shift_next   = shift_reg >> 1;
                        tx_next      = shift_reg[1];
                        bit_cnt_next = bit_cnt_reg + CW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last) begin
                    state_next    = STOP;
                    tx_next       = 1'b1;
                    stop_cnt_next = 1'b0;
                end
            end
`endif
            STOP: begin
                if (baud_last) begin
                    if (stop_last) begin
                        state_next = IDLE;
                    end else begin
                        stop_cnt_next = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase

        // Transfer overrides the IDLE exit of a finishing frame so frames run back to back.
        if (xfer) begin
            state_next     = START;
            shift_next     = hold_data_reg;
            tx_next        = 1'b0;
            hold_full_next = 1'b0;
            baud_cnt_next  = '0;
`ifdef UART_TX_PARITY_EN
            parity_next    = (^hold_data_reg) ^ 1'(PARITY_ODD);
`endif
        end

        if (load) begin
            hold_data_next = tx_data;
            hold_full_next = 1'b1;
        end
    end

    assign tx_ready = !hold_full_reg;
    assign tx       = tx_reg;
    assign busy     = (state_reg != IDLE);
    assign tx_done  = frame_end;

endmodule

// File: tb/tb_uart_master_tx.sv
// Bench for uart_master_tx: two instances (1 and 2 stop bits) checked every cycle against
// a bit-stream model of the serial line, holding register and frame timing.
`timescale 1ns/1ps
module tb_uart_master_tx;
    localparam int DW   = 8;
    localparam int BD   = 4;
    localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic          pclk   = 1'b0;
    logic          areset = 1'b1;
    logic [DW-1:0] tx_data_s  [2];
    logic          tx_valid_s [2];
    logic          tx_ready_s [2];
    logic          tx_s       [2];
    logic          busy_s     [2];
    logic          tx_done_s  [2];

    uart_master_tx #(.DATA_WIDTH(DW), .BAUD_DIV(BD), .STOP_BITS(1), .PARITY_ODD(PODD)) dut0 (
        .pclk(pclk), .areset(areset), .tx_data(tx_data_s[0]), .tx_valid(tx_valid_s[0]),
        .tx_ready(tx_ready_s[0]), .tx(tx_s[0]), .busy(busy_s[0]), .tx_done(tx_done_s[0])
    );

    uart_master_tx #(.DATA_WIDTH(DW), .BAUD_DIV(BD), .STOP_BITS(2), .PARITY_ODD(PODD)) dut1 (
        .pclk(pclk), .areset(areset), .tx_data(tx_data_s[1]), .tx_valid(tx_valid_s[1]),
        .tx_ready(tx_ready_s[1]), .tx(tx_s[1]), .busy(busy_s[1]), .tx_done(tx_done_s[1])
    );

    always #5 pclk = ~pclk;

    // Reference model: expected line samples per cycle, the holding register, pending sends.
    bit            line_q      [2][$];
    logic [DW-1:0] send_q      [2][$];
    int            xfer_cyc_q  [2][$];
    bit            hold_full_m [2];
    logic [DW-1:0] hold_m      [2];
    bit            drove_q     [2];
    bit            exp_tx      [2];
    bit            exp_busy    [2];
    bit            exp_done    [2];
    int            cyc;
    int            n_tests;
    int            n_fail;

    function automatic int stop_bits(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic int frame_len(input int i);
        return BD * (1 + DW + P + stop_bits(i));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_frame(input int i, input logic [DW-1:0] w);
        bit b [$];
        b.push_back(1'b0);
        for (int k = 0; k < DW; k++) b.push_back(w[k]);
        if (P == 1) b.push_back((^w) ^ 1'(PODD));
        for (int k = 0; k < stop_bits(i); k++) b.push_back(1'b1);
        foreach (b[k]) begin
            for (int r = 0; r < BD; r++) line_q[i].push_back(b[k]);
        end
    endtask

    task automatic model_step(input int i);
        bit hf;
        hf = hold_full_m[i];
        if (hf && line_q[i].size() == 0) begin
            push_frame(i, hold_m[i]);
            hold_full_m[i] = 1'b0;
            xfer_cyc_q[i].push_back(cyc);
        end
        if (tx_valid_s[i] && !hf) begin
            hold_m[i]      = tx_data_s[i];
            hold_full_m[i] = 1'b1;
            $display("[TB] dut%0d accept 0x%02h at cycle %0d", i, tx_data_s[i], cyc);
            if (drove_q[i] && send_q[i].size() > 0) void'(send_q[i].pop_front());
        end
        if (line_q[i].size() > 0) begin
            exp_tx[i]   = line_q[i].pop_front();
            exp_busy[i] = 1'b1;
            exp_done[i] = (line_q[i].size() == 0);
        end else begin
            exp_tx[i]   = 1'b1;
            exp_busy[i] = 1'b0;
            exp_done[i] = 1'b0;
        end
    endtask

    task automatic compare(input int i);
        int len;
        check($sformatf("dut%0d_tx", i), 32'(tx_s[i]), 32'(exp_tx[i]));
        check($sformatf("dut%0d_busy", i), 32'(busy_s[i]), 32'(exp_busy[i]));
        check($sformatf("dut%0d_done", i), 32'(tx_done_s[i]), 32'(exp_done[i]));
        check($sformatf("dut%0d_ready", i), 32'(tx_ready_s[i]), 32'(!hold_full_m[i]));
        if (tx_done_s[i]) begin
            len = (xfer_cyc_q[i].size() > 0) ? cyc - xfer_cyc_q[i].pop_front() + 1 : 0;
            check($sformatf("dut%0d_frame_len", i), 32'(len), 32'(frame_len(i)));
        end
    endtask

    // mode 0: send queued words as soon as possible, hold valid high while full.
    // mode 1: random gaps and random valid/data noise while the holding register is full.
    task automatic drive(input int i, input int mode);
        drove_q[i] = 1'b0;
        if (hold_full_m[i]) begin
            tx_valid_s[i] = (mode == 0) ? (send_q[i].size() > 0) : 1'($urandom_range(0, 1));
            tx_data_s[i]  = DW'($urandom);
        end else if (send_q[i].size() > 0 && (mode == 0 || $urandom_range(0, 3) != 0)) begin
            tx_valid_s[i] = 1'b1;
            tx_data_s[i]  = send_q[i][0];
            drove_q[i]    = 1'b1;
        end else begin
            tx_valid_s[i] = 1'b0;
            tx_data_s[i]  = DW'($urandom);
        end
    endtask

    task automatic run(input int n, input int mode);
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < 2; i++) drive(i, mode);
            @(posedge pclk);
            cyc++;
            for (int i = 0; i < 2; i++) model_step(i);
            @(negedge pclk);
            for (int i = 0; i < 2; i++) compare(i);
        end
    endtask

    task automatic check_idle(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_dut%0d_tx", tag, i), 32'(tx_s[i]), 32'd1);
            check($sformatf("%s_dut%0d_ready", tag, i), 32'(tx_ready_s[i]), 32'd1);
            check($sformatf("%s_dut%0d_busy", tag, i), 32'(busy_s[i]), 32'd0);
            check($sformatf("%s_dut%0d_done", tag, i), 32'(tx_done_s[i]), 32'd0);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            line_q[i].delete();
            send_q[i].delete();
            xfer_cyc_q[i].delete();
            hold_full_m[i] = 1'b0;
        end
    endtask

    initial begin
        int guard;
        cyc = 0;
        n_tests = 0;
        n_fail = 0;
        for (int i = 0; i < 2; i++) begin
            tx_valid_s[i] = 1'b0;
            tx_data_s[i]  = '0;
        end
        clear_model();

        repeat (3) @(negedge pclk);
        check_idle("reset");
        areset = 1'b0;

        // Single frames from idle, including the parity corner words.
        send_q[0].push_back(8'hA5);
        send_q[1].push_back(8'h3C);
        run(60, 0);
        send_q[0].push_back(8'h07);
        send_q[1].push_back(8'h07);
        run(60, 0);

        // Back-to-back with valid held high.
        for (int i = 0; i < 2; i++) begin
            send_q[i].push_back(8'h00);
            send_q[i].push_back(8'hFF);
        end
        run(140, 0);

        // Random words, random gaps, noise on the inputs while the holding register is full.
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 20; k++) send_q[i].push_back(DW'($urandom));
        end
        run(1200, 1);
        run(150, 0);

        // Reset in the middle of a frame.
        send_q[0].push_back(8'h5A);
        send_q[1].push_back(8'h5A);
        guard = 0;
        while (xfer_cyc_q[0].size() == 0 && guard < 10) begin
            run(1, 0);
            guard++;
        end
        check("mid_reset_frame_started", 32'(xfer_cyc_q[0].size()), 32'd1);
        run(14, 0);
        #1 areset = 1'b1;
        #1;
        check_idle("mid_reset");
        clear_model();
        @(posedge pclk);
        @(negedge pclk);
        check_idle("held_reset");
        areset = 1'b0;

        // Clean frame after reset.
        send_q[0].push_back(8'hC3);
        send_q[1].push_back(8'h96);
        run(60, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
